arbitro_sumador: RTL

Round-robin arbiter and sequencer that shares one registered 4-bit adder (`sumador`: `clk`, `enb`, `a`, `b`, `c`) among N requesters. It sits between the requesting blocks and the adder instance. It latches the winner's operands, drives the adder's enable and operand inputs, waits out the adder latency, and returns the sum to the winner with a one-cycle `done` pulse.

---
 rtl/sumador_pkg.sv | 18 +
 rtl/arbitro_sumador_if.sv | 30 +++
 rtl/selector_rr.sv | 31 +++
 rtl/arbitro_sumador.sv | 90 +++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - shared state encoding and defaults for the adder arbiter
package sumador_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      S_IDLE  = IDLE,
      S_ISSUE = ISSUE,
      S_WAIT  = WAIT,
      S_DONE  = DONE
   } state_t;

endpackage

// File: rtl/arbitro_sumador_if.sv
// rtl/arbitro_sumador_if.sv - requester and adder signals of the shared adder arbiter
interface arbitro_sumador_if
   import sumador_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] a_in;
   logic [N_REQ*WIDTH-1:0] b_in;
   logic [N_REQ-1:0]       gnt;
   logic [N_REQ-1:0]       done;
   logic [WIDTH-1:0]       result;
   logic                   busy;
   logic                   sum_enb;
   logic [WIDTH-1:0]       sum_a;
   logic [WIDTH-1:0]       sum_b;
   logic [WIDTH-1:0]       sum_c;

   modport master (
      input  req, a_in, b_in, sum_c,
      output gnt, done, result, busy, sum_enb, sum_a, sum_b
   );

   modport slave (
      output req, a_in, b_in, sum_c,
      input  gnt, done, result, busy, sum_enb, sum_a, sum_b
   );

endinterface

// File: rtl/selector_rr.sv
// rtl/selector_rr.sv - combinational round-robin pick starting after ptr, skipping masked requesters
module selector_rr #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic [N_REQ-1:0] win,
   output logic [IDX_W-1:0] win_idx
);

   always_comb begin : pick
      int   j;
      logic found;
      j       = 0;
      found   = 1'b0;
      win     = '0;
      win_idx = '0;
      // k = N_REQ revisits ptr itself, so a lone unmasked requester can win again
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!found && req[j] && !mask[j]) begin
            found   = 1'b1;
            win[j]  = 1'b1;
            win_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/arbitro_sumador.sv
// rtl/arbitro_sumador.sv - round-robin sequencer sharing one registered adder among N_REQ requesters
module arbitro_sumador
   import sumador_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LAT   = 1
) (
   input logic              clk,
   input logic              reset,
   arbitro_sumador_if.master bus
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CW    = (LAT < 2) ? 1 : $clog2(LAT + 1);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [CW-1:0]    cnt;
   logic [N_REQ-1:0] mask;
   logic [N_REQ-1:0] win;
   logic [IDX_W-1:0] win_idx;
   logic             any_win;

   // In DONE the finishing requester still holds req, so it is excluded from the next pick
   assign mask    = (state == S_DONE) ? bus.gnt : '0;
   assign any_win = |win;

   selector_rr #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_selector_rr (
      .req     (bus.req),
      .ptr     (ptr),
      .mask    (mask),
      .win     (win),
      .win_idx (win_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         ptr         <= IDX_W'(N_REQ - 1);
         cnt         <= '0;
         bus.gnt     <= '0;
         bus.done    <= '0;
         bus.result  <= '0;
         bus.busy    <= 1'b0;
         bus.sum_enb <= 1'b0;
         bus.sum_a   <= '0;
         bus.sum_b   <= '0;
      end else begin
         bus.sum_enb <= 1'b0;
         bus.done    <= '0;
         case (state)
            S_IDLE, S_DONE: begin
               if (any_win) begin
                  // sum_a/sum_b double as the operand latch for the whole operation
                  bus.gnt     <= win;
                  ptr         <= win_idx;
                  bus.sum_a   <= bus.a_in[win_idx*WIDTH +: WIDTH];
                  bus.sum_b   <= bus.b_in[win_idx*WIDTH +: WIDTH];
                  bus.sum_enb <= 1'b1;
                  bus.busy    <= 1'b1;
                  state       <= S_ISSUE;
               end else begin
                  bus.gnt  <= '0;
                  bus.busy <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            S_ISSUE: begin
               cnt   <= CW'(LAT);
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == CW'(1)) begin
                  bus.result <= bus.sum_c;
                  bus.done   <= bus.gnt;
                  state      <= S_DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
